// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB arbiter: FSM encoding and default sizing.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_e;

    localparam int unsigned AWID_DEF    = 32;
    localparam int unsigned DWID_DEF    = 8;
    localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/apb_arb_rr.sv
// Two-way round-robin pick: on contention the requester not granted last wins.
module apb_arb_rr (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_gnt
);

    always_comb begin
        o_gnt = 1'b0;
        case (i_req)
            2'b01:   o_gnt = 1'b0;
            2'b10:   o_gnt = 1'b1;
            2'b11:   o_gnt = ~i_last;
            default: o_gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_master_arb.sv
// Arbitrates two upstream APB requesters onto one downstream APB master port,
// with a bounded ACCESS phase that forces an error completion on timeout.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int unsigned AWID    = AWID_DEF,
    parameter int unsigned DWID    = DWID_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic            pclk,
    input  logic            rst_i,
    input  logic            m0_psel,
    input  logic            m0_penable,
    input  logic            m0_pwrite,
    input  logic [AWID-1:0] m0_paddr,
    input  logic [DWID-1:0] m0_pwdata,
    output logic            m0_pready,
    output logic            m0_pslverr,
    output logic [DWID-1:0] m0_prdata,
    input  logic            m1_psel,
    input  logic            m1_penable,
    input  logic            m1_pwrite,
    input  logic [AWID-1:0] m1_paddr,
    input  logic [DWID-1:0] m1_pwdata,
    output logic            m1_pready,
    output logic            m1_pslverr,
    output logic [DWID-1:0] m1_prdata,
    output logic            s_psel,
    output logic            s_penable,
    output logic            s_pwrite,
    output logic [AWID-1:0] s_paddr,
    output logic [DWID-1:0] s_pwdata,
    input  logic            s_pready,
    input  logic            s_pslverr,
    input  logic [DWID-1:0] s_prdata,
    output logic            timeout_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e          r_state;
    logic            r_gnt;
    logic            r_last;
    logic            r_abort;
    logic            r_psel;
    logic            r_penable;
    logic            r_pwrite;
    logic [AWID-1:0] r_paddr;
    logic [DWID-1:0] r_pwdata;
    logic [7:0]      r_cnt;

    logic            w_pick;
    logic            w_gsel;
    logic            w_access;
    logic            w_ok;
    logic            w_to;
    logic            w_keep;
    logic            w_err;
    logic [DWID-1:0] w_rdata;
    logic            w_unused;

    // Upstream penable carries no information the arbiter needs.
    assign w_unused = m0_penable ^ m1_penable;

    apb_arb_rr u_rr (
        .i_req  ({m1_psel, m0_psel}),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    assign w_gsel   = r_gnt ? m1_psel : m0_psel;
    assign w_access = (r_state == StAccess) && !rst_i;
    assign w_ok     = w_access && s_pready;
    assign w_to     = w_access && !s_pready && (r_cnt == CNT_LAST);
    // A requester that let go of psel mid-transfer never sees the result.
    assign w_keep   = (w_ok || w_to) && w_gsel && !r_abort;
    assign w_err    = w_ok ? s_pslverr : 1'b1;
    assign w_rdata  = w_ok ? s_prdata : '0;

    assign m0_pready  = w_keep && !r_gnt;
    assign m0_pslverr = m0_pready && w_err;
    assign m0_prdata  = m0_pready ? w_rdata : '0;
    assign m1_pready  = w_keep && r_gnt;
    assign m1_pslverr = m1_pready && w_err;
    assign m1_prdata  = m1_pready ? w_rdata : '0;
    assign timeout_o  = w_to;

    assign s_psel    = r_psel;
    assign s_penable = r_penable;
    assign s_pwrite  = r_pwrite;
    assign s_paddr   = r_paddr;
    assign s_pwdata  = r_pwdata;

    always_ff @(posedge pclk) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_abort   <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_cnt     <= 8'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (m0_psel || m1_psel) begin
                        r_gnt     <= w_pick;
                        r_last    <= w_pick;
                        r_abort   <= 1'b0;
                        r_paddr   <= w_pick ? m1_paddr : m0_paddr;
                        r_pwdata  <= w_pick ? m1_pwdata : m0_pwdata;
                        r_pwrite  <= w_pick ? m1_pwrite : m0_pwrite;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= StSetup;
                    end
                end
                StSetup: begin
                    r_penable <= 1'b1;
                    r_cnt     <= 8'd0;
                    r_state   <= StAccess;
                    if (!w_gsel) r_abort <= 1'b1;
                end
                StAccess: begin
                    if (!w_gsel) r_abort <= 1'b1;
                    if (w_ok || w_to) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: stimulus queues expected responses, a monitor checks them.
module tb_apb_master_arb;

    typedef struct {
        logic       who;
        logic [7:0] rdata;
        logic       err;
        logic       to;
    } rsp_t;

    logic        pclk = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_psel = 1'b0, m0_penable = 1'b0, m0_pwrite = 1'b0;
    logic [31:0] m0_paddr = '0;
    logic [7:0]  m0_pwdata = '0;
    logic        m0_pready, m0_pslverr;
    logic [7:0]  m0_prdata;
    logic        m1_psel = 1'b0, m1_penable = 1'b0, m1_pwrite = 1'b0;
    logic [31:0] m1_paddr = '0;
    logic [7:0]  m1_pwdata = '0;
    logic        m1_pready, m1_pslverr;
    logic [7:0]  m1_prdata;
    logic        s_psel, s_penable, s_pwrite;
    logic [31:0] s_paddr;
    logic [7:0]  s_pwdata;
    logic        s_pready = 1'b0, s_pslverr = 1'b0;
    logic [7:0]  s_prdata = '0;
    logic        timeout_o;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_rsp = 0;
    int   n_slv = 0;
    int   cfg_wait = 0;
    logic [7:0] cfg_rdata = '0;
    logic cfg_err = 1'b0;
    rsp_t exp_q[$];

    apb_master_arb #(.AWID(32), .DWID(8), .TIMEOUT(4)) dut (
        .pclk       (pclk),
        .rst_i      (rst_i),
        .m0_psel    (m0_psel),
        .m0_penable (m0_penable),
        .m0_pwrite  (m0_pwrite),
        .m0_paddr   (m0_paddr),
        .m0_pwdata  (m0_pwdata),
        .m0_pready  (m0_pready),
        .m0_pslverr (m0_pslverr),
        .m0_prdata  (m0_prdata),
        .m1_psel    (m1_psel),
        .m1_penable (m1_penable),
        .m1_pwrite  (m1_pwrite),
        .m1_paddr   (m1_paddr),
        .m1_pwdata  (m1_pwdata),
        .m1_pready  (m1_pready),
        .m1_pslverr (m1_pslverr),
        .m1_prdata  (m1_prdata),
        .s_psel     (s_psel),
        .s_penable  (s_penable),
        .s_pwrite   (s_pwrite),
        .s_paddr    (s_paddr),
        .s_pwdata   (s_pwdata),
        .s_pready   (s_pready),
        .s_pslverr  (s_pslverr),
        .s_prdata   (s_prdata),
        .timeout_o  (timeout_o)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push(input logic who, input logic [7:0] rdata, input logic err,
                        input logic to);
        rsp_t e;
        e.who = who; e.rdata = rdata; e.err = err; e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic wait_rsp(input int target, input int max_cyc, output int cyc);
        cyc = 0;
        while (n_rsp < target && cyc < max_cyc) begin
            @(negedge pclk);
            #3;
            cyc++;
        end
        if (n_rsp < target) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_wait: got %0d responses expected %0d", n_rsp, target);
        end
    endtask

    // Slave: ready after cfg_wait ACCESS cycles that were not ready.
    int acc = 0;
    always @(negedge pclk) begin
        if (s_psel && s_penable) begin
            s_pready = (acc == cfg_wait);
            if (s_pready) n_slv++;
            acc++;
        end else begin
            s_pready = 1'b0;
            acc = 0;
        end
        s_prdata  = cfg_rdata;
        s_pslverr = cfg_err;
    end

    always begin : monitor
        rsp_t e;
        @(negedge pclk);
        #2;
        if (m0_pready || m1_pready || timeout_o) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: m0_pready=%b m1_pready=%b timeout_o=%b, none expected",
                         m0_pready, m1_pready, timeout_o);
            end else begin
                e = exp_q.pop_front();
                check("rsp_m0_pready", {31'd0, m0_pready}, {31'd0, ~e.who});
                check("rsp_m1_pready", {31'd0, m1_pready}, {31'd0, e.who});
                check("rsp_prdata", {24'd0, e.who ? m1_prdata : m0_prdata}, {24'd0, e.rdata});
                check("rsp_pslverr", {31'd0, e.who ? m1_pslverr : m0_pslverr}, {31'd0, e.err});
                check("rsp_other_idle", {23'd0, e.who ? {m0_pslverr, m0_prdata}
                                                       : {m1_pslverr, m1_prdata}}, 32'd0);
                check("rsp_timeout", {31'd0, timeout_o}, {31'd0, e.to});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        tick();
        tick();
        check("rst_s_psel", {31'd0, s_psel}, 0);
        check("rst_s_penable", {31'd0, s_penable}, 0);
        check("rst_s_paddr", s_paddr, 0);
        check("rst_s_pwdata", {24'd0, s_pwdata}, 0);
        check("rst_s_pwrite", {31'd0, s_pwrite}, 0);
        check("rst_timeout", {31'd0, timeout_o}, 0);
        rst_i = 1'b0;
        tick();

        // Single zero-wait read by m0.
        cfg_wait = 0; cfg_rdata = 8'h5A; cfg_err = 1'b0;
        push(1'b0, 8'h5A, 1'b0, 1'b0);
        m0_psel = 1'b1; m0_paddr = 32'h8004; m0_pwrite = 1'b0;
        tick();
        check("rd_n1_psel", {31'd0, s_psel}, 1);
        check("rd_n1_penable", {31'd0, s_penable}, 0);
        check("rd_n1_paddr", s_paddr, 32'h8004);
        m0_penable = 1'b1;
        tick();
        check("rd_n2_penable", {31'd0, s_penable}, 1);
        @(negedge pclk);
        #3;
        check("rd_n2_m0_pready", {31'd0, m0_pready}, 1);
        check("rd_n2_m1_pready", {31'd0, m1_pready}, 0);
        m0_psel = 1'b0; m0_penable = 1'b0;
        tick();
        check("rd_idle_psel", {31'd0, s_psel}, 0);
        check("rd_idle_paddr_hold", s_paddr, 32'h8004);

        // Contention straight out of reset: grants alternate 0,1,0,1.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        cfg_rdata = 8'h11;
        push(1'b0, 8'h11, 1'b0, 1'b0);
        push(1'b1, 8'h11, 1'b0, 1'b0);
        push(1'b0, 8'h11, 1'b0, 1'b0);
        push(1'b1, 8'h11, 1'b0, 1'b0);
        m0_psel = 1'b1; m0_paddr = 32'h10;
        m1_psel = 1'b1; m1_paddr = 32'h20;
        wait_rsp(n_rsp + 4, 40, cyc);
        m0_psel = 1'b0; m1_psel = 1'b0;
        tick();

        // m1 read with 3 wait states ending in slave error.
        cfg_wait = 3; cfg_rdata = 8'h77; cfg_err = 1'b1;
        push(1'b1, 8'h77, 1'b1, 1'b0);
        m1_psel = 1'b1; m1_paddr = 32'h30;
        wait_rsp(n_rsp + 1, 20, cyc);
        check("ws_latency", cyc, 6);
        m1_psel = 1'b0;
        tick();

        // m0 write to a slave that never answers.
        cfg_wait = 255; cfg_rdata = 8'hEE; cfg_err = 1'b0;
        push(1'b0, 8'h00, 1'b1, 1'b1);
        m0_psel = 1'b1; m0_paddr = 32'h40; m0_pwdata = 8'hC3; m0_pwrite = 1'b1;
        wait_rsp(n_rsp + 1, 20, cyc);
        check("to_latency", cyc, 6);
        m0_psel = 1'b0;
        tick();
        check("to_psel_drop", {31'd0, s_psel}, 0);
        check("to_pulse_once", {31'd0, timeout_o}, 0);

        // Reset in the middle of an m0 write to 0x0003.
        m0_psel = 1'b1; m0_paddr = 32'h3; m0_pwdata = 8'h99; m0_pwrite = 1'b1;
        tick();
        tick();
        check("mid_penable", {31'd0, s_penable}, 1);
        check("mid_pwdata", {24'd0, s_pwdata}, 32'h99);
        check("mid_pwrite", {31'd0, s_pwrite}, 1);
        rst_i = 1'b1;
        tick();
        check("mid_rst_psel", {31'd0, s_psel}, 0);
        check("mid_rst_penable", {31'd0, s_penable}, 0);
        check("mid_rst_paddr", s_paddr, 0);
        check("mid_rst_pwdata", {24'd0, s_pwdata}, 0);
        check("mid_rst_pwrite", {31'd0, s_pwrite}, 0);
        check("mid_rst_m0_pready", {31'd0, m0_pready}, 0);
        rst_i = 1'b0;
        m0_pwrite = 1'b0;
        cfg_wait = 0; cfg_rdata = 8'h3C;
        push(1'b0, 8'h3C, 1'b0, 1'b0);
        m0_paddr = 32'h60;
        m1_psel = 1'b1; m1_paddr = 32'h70; m1_pwrite = 1'b0;
        wait_rsp(n_rsp + 1, 20, cyc);
        m0_psel = 1'b0; m1_psel = 1'b0;
        tick();

        // m1 drops psel during SETUP; downstream still completes, result discarded.
        cfg_wait = 1; cfg_rdata = 8'hA5;
        m1_psel = 1'b1; m1_paddr = 32'h50;
        cyc = n_slv;
        tick();
        check("abort_setup_psel", {31'd0, s_psel}, 1);
        m1_psel = 1'b0;
        repeat (4) tick();
        check("abort_idle_psel", {31'd0, s_psel}, 0);
        check("abort_slave_done", n_slv - cyc, 1);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 SHALL have parameter AWID, default 32, upstream/downstream address width.
REQ-002 SHALL have parameter DWID, default 8, data width, matching the 8-bit peripheral cluster bus.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum ACCESS-phase cycles before forced error completion; legal range 1..255.
REQ-004 SHALL have port pclk, input, 1, the single clock.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports m0_psel/m0_penable/m0_pwrite, input, 1 each, requester 0 APB controls.
REQ-007 SHALL have ports m0_paddr, input, AWID, and m0_pwdata, input, DWID, requester 0 address and write data.
REQ-008 SHALL have ports m0_pready/m0_pslverr, output, 1 each, and m0_prdata, output, DWID, requester 0 response.
REQ-009 SHALL have ports m1_*, identical to m0_* in direction and width, for requester 1.
REQ-010 SHALL have ports s_psel/s_penable/s_pwrite, output, 1 each; s_paddr, output, AWID; s_pwdata, output, DWID; these form the downstream APB master port to the cluster.
REQ-011 SHALL have ports s_pready/s_pslverr, input, 1 each, and s_prdata, input, DWID.
REQ-012 SHALL have port timeout_o, output, 1, a one-cycle pulse on each forced completion.

Function
REQ-013 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-014 IDLE: if any mX_psel=1, SHALL grant, latch the granted requester's paddr/pwdata/pwrite into registers, and go to SETUP next cycle.
REQ-015 Arbitration when both request SHALL be round-robin: grant the requester not granted last; the last-grant pointer resets to 1 so m0 wins first.
REQ-016 SETUP SHALL drive s_psel=1, s_penable=0 and the latched address/data/write, then go to ACCESS unconditionally.
REQ-017 ACCESS SHALL drive s_psel=1, s_penable=1, hold latched values, and increment an 8-bit wait counter that is cleared on entry.
REQ-018 In ACCESS with s_pready=1, SHALL combinationally assert the granted mX_pready=1, pass s_prdata to mX_prdata and s_pslverr to mX_pslverr, and return to IDLE.
REQ-019 In ACCESS with s_pready=0 and the counter at TIMEOUT-1, SHALL complete with mX_pready=1, mX_pslverr=1, mX_prdata=0, timeout_o=1, and return to IDLE; s_psel drops next cycle.
REQ-020 The non-granted requester SHALL see pready=0, pslverr=0, prdata=0 at all times.
REQ-021 Outputs s_* SHALL be registered; in IDLE s_psel=s_penable=0, with s_paddr/s_pwdata/s_pwrite holding their last values.
REQ-022 Minimum latency SHALL be: psel seen in IDLE at cycle N -> s_psel at N+1 -> s_penable at N+2 -> mX_pready at N+2 for a zero-wait slave; one IDLE cycle SHALL follow every completion.
REQ-023 If the granted requester drops psel mid-transfer, the downstream transfer SHALL still complete and the result SHALL be discarded.
REQ-024 A requester whose psel stays high after pready SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-025 rst_i=1 on a pclk edge SHALL force IDLE; all outputs 0; wait counter 0; last-grant pointer 1; latched address/data/write 0.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer without any mX_pready, and s_psel SHALL be 0 in the cycle after the reset edge.

Structure
REQ-027 A shared package apb_arb_pkg SHALL hold the FSM state encoding (IDLE/SETUP/ACCESS) and the default AWID/DWID/TIMEOUT constants.
REQ-028 The 2-way round-robin pick SHALL be a sub-module apb_arb_rr (inputs: req[1:0], last; output: grant index); all other logic stays flat.

Verification
REQ-029 Single read: m0 reads 0x8004, slave zero-wait with prdata=0x5A -> s_psel at N+1, s_penable at N+2, m0_pready=1 with m0_prdata=0x5A at N+2, m1_pready stays 0.
REQ-030 Contention: m0 and m1 request in the same cycle from reset -> m0 served first, then m1; with both requesting continuously, grants alternate 0,1,0,1.
REQ-031 Wait states: slave holds s_pready=0 for 3 ACCESS cycles, then s_pready=1 with s_pslverr=1 -> m1_pready and m1_pslverr pulse together once; timeout_o stays 0.
REQ-032 Timeout: TIMEOUT=4, slave never ready -> after 4 ACCESS cycles mX_pready=1, mX_pslverr=1, mX_prdata=0, timeout_o pulses once; s_psel=0 next cycle.
REQ-033 Reset mid-ACCESS: rst_i pulsed during a write to 0x0003 -> no mX_pready pulse, all outputs 0 next cycle, next grant goes to m0.
REQ-034 Abort: m1 drops psel during SETUP -> downstream transfer still completes, m1_pready is never seen by m1 afterwards, FSM returns to IDLE.
